// File: rtl/pp_loop_status_tracker.sv
// rtl/pp_loop_status_tracker.sv - HLS kernel block/pipelined-loop status monitor with saturating counters
module pp_loop_status_tracker #(
    parameter int FSM_W = 3,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             finish,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic [FSM_W-1:0] cur_state,
    input  logic [FSM_W-1:0] pre_loop_state0,
    input  logic [FSM_W-1:0] post_loop_state0,
    input  logic [FSM_W-1:0] iter_start_state,
    input  logic [FSM_W-1:0] iter_end_state,
    input  logic [FSM_W-1:0] loop_quit_state,
    input  logic             pre_states_valid,
    input  logic             post_states_valid,
    input  logic             quit_at_end,
    input  logic             iter_start_enable,
    input  logic             iter_start_block,
    input  logic             iter_end_enable,
    input  logic             iter_end_block,
    output logic             mod_busy,
    output logic [CNT_W-1:0] mod_txn_cnt,
    output logic [CNT_W-1:0] mod_last_lat,
    output logic             loop_active,
    output logic [CNT_W-1:0] loop_entry_cnt,
    output logic [CNT_W-1:0] iter_start_cnt,
    output logic [CNT_W-1:0] iter_end_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] loop_last_lat,
    output logic [CNT_W-1:0] iter_inflight,
    output logic             err_flag,
    output logic             dump_valid
);

    typedef enum logic [1:0] {M_IDLE, M_BUSY, M_WAIT} m_state_t;
    typedef enum logic {L_OUT, L_IN} l_state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    // ap_ready carries no information the monitor needs beyond ap_done
    logic unused_ap_ready;
    assign unused_ap_ready = ap_ready;

    m_state_t         m_state, m_state_n;
    l_state_t         l_state, l_state_n;
    logic [CNT_W-1:0] m_lat, m_lat_n, l_lat, l_lat_n;
    logic [CNT_W-1:0] txn_n, mlast_n, entry_n, start_n, end_n, stall_n, llast_n, infl_n;
    logic [FSM_W-1:0] prev_state, prev_n;
    logic             err_n, frozen, frozen_n, dump_n;

    logic in_start, in_end, in_post, in_quit, prev_in_pre;
    logic run, start_ev, end_ev, stall_ev, exit_ev;

    assign in_start    = |(cur_state & iter_start_state);
    assign in_end      = |(cur_state & iter_end_state);
    assign in_post     = |(cur_state & post_loop_state0);
    assign in_quit     = |(cur_state & loop_quit_state);
    assign prev_in_pre = |(prev_state & pre_loop_state0);

    assign run      = !finish && !frozen;
    assign start_ev = in_start && iter_start_enable && !iter_start_block;
    assign end_ev   = in_end && iter_end_enable && !iter_end_block;
    assign stall_ev = in_start && iter_start_enable && iter_start_block;
    assign exit_ev  = post_states_valid ? in_post : !in_quit;

    always_comb begin
        m_state_n = m_state;
        l_state_n = l_state;
        m_lat_n   = m_lat;
        l_lat_n   = l_lat;
        txn_n     = mod_txn_cnt;
        mlast_n   = mod_last_lat;
        entry_n   = loop_entry_cnt;
        start_n   = iter_start_cnt;
        end_n     = iter_end_cnt;
        stall_n   = stall_cnt;
        llast_n   = loop_last_lat;
        infl_n    = iter_inflight;
        err_n     = err_flag;
        prev_n    = prev_state;
        dump_n    = finish && !frozen;
        frozen_n  = frozen || finish;

        if (run) begin
            prev_n = cur_state;

            case (m_state)
                M_IDLE: begin
                    if (ap_start) begin
                        m_state_n = M_BUSY;
                        m_lat_n   = ONE;
                    end
                end
                M_BUSY: begin
                    if (ap_done) begin
                        // latency is inclusive of the done cycle itself
                        txn_n   = sat_inc(mod_txn_cnt);
                        mlast_n = sat_inc(m_lat);
                        if (ap_continue && ap_start) begin
                            m_lat_n = ONE;
                        end else if (ap_continue) begin
                            m_state_n = M_IDLE;
                        end else begin
                            m_state_n = M_WAIT;
                        end
                    end else begin
                        m_lat_n = sat_inc(m_lat);
                    end
                end
                M_WAIT: begin
                    if (ap_continue) begin
                        m_state_n = M_IDLE;
                    end
                end
                default: m_state_n = M_IDLE;
            endcase

            case (l_state)
                L_OUT: begin
                    if (in_start && (!pre_states_valid || prev_in_pre)) begin
                        l_state_n = L_IN;
                        entry_n   = sat_inc(loop_entry_cnt);
                        infl_n    = '0;
                        l_lat_n   = ONE;
                    end
                end
                L_IN: begin
                    if (start_ev) start_n = sat_inc(iter_start_cnt);
                    if (end_ev)   end_n   = sat_inc(iter_end_cnt);
                    if (stall_ev) stall_n = sat_inc(stall_cnt);
                    if (start_ev && !end_ev) begin
                        infl_n = sat_inc(iter_inflight);
                    end else if (end_ev && !start_ev && iter_inflight != '0) begin
                        infl_n = iter_inflight - ONE;
                    end
                    if (exit_ev) begin
                        l_state_n = L_OUT;
                        llast_n   = sat_inc(l_lat);
                        if (quit_at_end && iter_inflight != '0) err_n = 1'b1;
                    end else begin
                        l_lat_n = sat_inc(l_lat);
                    end
                end
                default: l_state_n = L_OUT;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_state        <= M_IDLE;
            l_state        <= L_OUT;
            m_lat          <= '0;
            l_lat          <= '0;
            mod_txn_cnt    <= '0;
            mod_last_lat   <= '0;
            loop_entry_cnt <= '0;
            iter_start_cnt <= '0;
            iter_end_cnt   <= '0;
            stall_cnt      <= '0;
            loop_last_lat  <= '0;
            iter_inflight  <= '0;
            err_flag       <= 1'b0;
            prev_state     <= '0;
            frozen         <= 1'b0;
            dump_valid     <= 1'b0;
        end else begin
            m_state        <= m_state_n;
            l_state        <= l_state_n;
            m_lat          <= m_lat_n;
            l_lat          <= l_lat_n;
            mod_txn_cnt    <= txn_n;
            mod_last_lat   <= mlast_n;
            loop_entry_cnt <= entry_n;
            iter_start_cnt <= start_n;
            iter_end_cnt   <= end_n;
            stall_cnt      <= stall_n;
            loop_last_lat  <= llast_n;
            iter_inflight  <= infl_n;
            err_flag       <= err_n;
            prev_state     <= prev_n;
            frozen         <= frozen_n;
            dump_valid     <= dump_n;
        end
    end

    assign mod_busy    = (m_state != M_IDLE);
    assign loop_active = (l_state == L_IN);

endmodule

// File: tb/tb_pp_loop_status_tracker.sv
// tb/tb_pp_loop_status_tracker.sv - directed + randomized checks of pp_loop_status_tracker against a timestamp model
module tb_pp_loop_status_tracker;

    localparam int FSM_W = 3;
    localparam int CNT_W = 6;
    localparam int MAXV  = (1 << CNT_W) - 1;

    localparam logic [2:0] S_PRE  = 3'b001;
    localparam logic [2:0] S_PP0  = 3'b010;
    localparam logic [2:0] S_POST = 3'b100;

    logic clock = 1'b0;
    logic reset, finish, ap_start, ap_ready, ap_done, ap_continue;
    logic [FSM_W-1:0] cur_state, pre_loop_state0, post_loop_state0;
    logic [FSM_W-1:0] iter_start_state, iter_end_state, loop_quit_state;
    logic pre_states_valid, post_states_valid, quit_at_end;
    logic iter_start_enable, iter_start_block, iter_end_enable, iter_end_block;
    logic mod_busy, loop_active, err_flag, dump_valid;
    logic [CNT_W-1:0] mod_txn_cnt, mod_last_lat, loop_entry_cnt, iter_start_cnt;
    logic [CNT_W-1:0] iter_end_cnt, stall_cnt, loop_last_lat, iter_inflight;

    always #5 clock = ~clock;

    pp_loop_status_tracker #(.FSM_W(FSM_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .finish(finish),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .cur_state(cur_state), .pre_loop_state0(pre_loop_state0), .post_loop_state0(post_loop_state0),
        .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
        .loop_quit_state(loop_quit_state), .pre_states_valid(pre_states_valid),
        .post_states_valid(post_states_valid), .quit_at_end(quit_at_end),
        .iter_start_enable(iter_start_enable), .iter_start_block(iter_start_block),
        .iter_end_enable(iter_end_enable), .iter_end_block(iter_end_block),
        .mod_busy(mod_busy), .mod_txn_cnt(mod_txn_cnt), .mod_last_lat(mod_last_lat),
        .loop_active(loop_active), .loop_entry_cnt(loop_entry_cnt), .iter_start_cnt(iter_start_cnt),
        .iter_end_cnt(iter_end_cnt), .stall_cnt(stall_cnt), .loop_last_lat(loop_last_lat),
        .iter_inflight(iter_inflight), .err_flag(err_flag), .dump_valid(dump_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: transactions and loop runs tracked by their start timestamps
    int cyc = 0;
    int mst, t_m, txn, mlast;
    bit lin;
    int t_l, entries, starts, ends, stalls, llast, infl;
    bit err, frozen, dump;
    logic [2:0] prevst;

    function automatic int sat(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    function automatic bit hit(input logic [2:0] a, input logic [2:0] b);
        return |(a & b);
    endfunction

    task automatic model_reset();
        mst = 0; t_m = 0; txn = 0; mlast = 0;
        lin = 0; t_l = 0; entries = 0; starts = 0; ends = 0; stalls = 0; llast = 0; infl = 0;
        err = 0; frozen = 0; dump = 0; prevst = '0;
    endtask

    task automatic model_update();
        bit st, en, sl, ex;
        cyc++;
        if (!reset) begin
            model_reset();
        end else begin
            dump = finish && !frozen;
            if (!finish && !frozen) begin
                if (mst == 0) begin
                    if (ap_start) begin mst = 1; t_m = cyc; end
                end else if (mst == 1) begin
                    if (ap_done) begin
                        txn   = sat(txn + 1);
                        mlast = sat(cyc - t_m + 1);
                        if (ap_continue && ap_start) t_m = cyc;
                        else if (ap_continue) mst = 0;
                        else mst = 2;
                    end
                end else begin
                    if (ap_continue) mst = 0;
                end

                if (!lin) begin
                    if (hit(cur_state, iter_start_state) &&
                        (!pre_states_valid || hit(prevst, pre_loop_state0))) begin
                        lin = 1; entries = sat(entries + 1); infl = 0; t_l = cyc;
                    end
                end else begin
                    st = hit(cur_state, iter_start_state) && iter_start_enable && !iter_start_block;
                    en = hit(cur_state, iter_end_state) && iter_end_enable && !iter_end_block;
                    sl = hit(cur_state, iter_start_state) && iter_start_enable && iter_start_block;
                    ex = post_states_valid ? hit(cur_state, post_loop_state0) : !hit(cur_state, loop_quit_state);
                    if (st) starts = sat(starts + 1);
                    if (en) ends = sat(ends + 1);
                    if (sl) stalls = sat(stalls + 1);
                    if (ex && quit_at_end && infl != 0) err = 1;
                    if (st && !en) infl = sat(infl + 1);
                    else if (en && !st && infl > 0) infl = infl - 1;
                    if (ex) begin lin = 0; llast = sat(cyc - t_l + 1); end
                end
                prevst = cur_state;
            end
            frozen = frozen || finish;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("mod_busy",       32'(mod_busy),       32'(mst != 0));
        chk("mod_txn_cnt",    32'(mod_txn_cnt),    32'(txn));
        chk("mod_last_lat",   32'(mod_last_lat),   32'(mlast));
        chk("loop_active",    32'(loop_active),    32'(lin));
        chk("loop_entry_cnt", 32'(loop_entry_cnt), 32'(entries));
        chk("iter_start_cnt", 32'(iter_start_cnt), 32'(starts));
        chk("iter_end_cnt",   32'(iter_end_cnt),   32'(ends));
        chk("stall_cnt",      32'(stall_cnt),      32'(stalls));
        chk("loop_last_lat",  32'(loop_last_lat),  32'(llast));
        chk("iter_inflight",  32'(iter_inflight),  32'(infl));
        chk("err_flag",       32'(err_flag),       32'(err));
        chk("dump_valid",     32'(dump_valid),     32'(dump));
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic idle_inputs();
        finish = 0; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
        cur_state = '0; iter_start_enable = 0; iter_start_block = 0;
        iter_end_enable = 0; iter_end_block = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        run(2);
        reset = 1;
    endtask

    initial begin
        pre_loop_state0 = S_PRE; post_loop_state0 = S_POST;
        iter_start_state = S_PP0; iter_end_state = S_PP0; loop_quit_state = S_PP0;
        pre_states_valid = 1; post_states_valid = 1; quit_at_end = 1;
        idle_inputs();
        model_reset();
        do_reset();

        // single transaction: start cycle 0, done cycle 9
        ap_start = 1; step();
        ap_start = 0; run(8);
        ap_done = 1; ap_continue = 1; step();
        ap_done = 0; ap_continue = 0; step();
        chk("txn_cnt_one", 32'(mod_txn_cnt), 32'd1);
        chk("txn_lat_ten", 32'(mod_last_lat), 32'd10);
        chk("txn_busy_low", 32'(mod_busy), 32'd0);

        // back-to-back transaction, done with continue withheld, then continue
        ap_start = 1; step();
        ap_start = 0; run(2);
        ap_done = 1; ap_continue = 1; ap_start = 1; step();
        ap_done = 0; ap_continue = 0; ap_start = 0; run(3);
        ap_done = 1; step();
        ap_done = 0; run(2);
        chk("wait_busy", 32'(mod_busy), 32'd1);
        ap_continue = 1; step();
        ap_continue = 0; ap_done = 1; step();
        ap_done = 0; step();
        chk("txn_cnt_three", 32'(mod_txn_cnt), 32'd3);

        // clean loop: 5 iterations started then 5 ended
        cur_state = S_PRE; step();
        cur_state = S_PP0; step();
        iter_start_enable = 1; run(5);
        iter_start_enable = 0; run(3);
        iter_end_enable = 1; run(5);
        iter_end_enable = 0; cur_state = S_POST; step();
        cur_state = '0; step();
        chk("loop1_entry", 32'(loop_entry_cnt), 32'd1);
        chk("loop1_starts", 32'(iter_start_cnt), 32'd5);
        chk("loop1_ends", 32'(iter_end_cnt), 32'd5);
        chk("loop1_err", 32'(err_flag), 32'd0);
        chk("loop1_lat", 32'(loop_last_lat), 32'd15);

        // same loop with 3 blocked enabled cycles
        cur_state = S_PRE; step();
        cur_state = S_PP0; step();
        iter_start_enable = 1; iter_start_block = 1; run(3);
        iter_start_block = 0; run(5);
        iter_start_enable = 0; iter_end_enable = 1; run(5);
        iter_end_enable = 0; cur_state = S_POST; step();
        cur_state = '0; step();
        chk("loop2_stall", 32'(stall_cnt), 32'd3);
        chk("loop2_starts", 32'(iter_start_cnt), 32'd10);

        // exit with 2 iterations in flight
        cur_state = S_PRE; step();
        cur_state = S_PP0; step();
        iter_start_enable = 1; run(5);
        iter_start_enable = 0; iter_end_enable = 1; run(3);
        iter_end_enable = 0; cur_state = S_POST; step();
        cur_state = S_PRE; run(5);
        chk("loop3_err_sticky", 32'(err_flag), 32'd1);

        // randomized traffic with occasional reset
        for (int i = 0; i < 1500; i++) begin
            ap_start    = ($urandom_range(0, 3) == 0);
            ap_done     = ($urandom_range(0, 4) == 0);
            ap_continue = ($urandom_range(0, 1) == 0);
            ap_ready    = $urandom_range(0, 1);
            case ($urandom_range(0, 4))
                0: cur_state = 3'b000;
                1: cur_state = S_PRE;
                2: cur_state = S_POST;
                default: cur_state = S_PP0;
            endcase
            iter_start_enable = $urandom_range(0, 1);
            iter_start_block  = ($urandom_range(0, 3) == 0);
            iter_end_enable   = $urandom_range(0, 1);
            iter_end_block    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) begin
                pre_states_valid  = $urandom_range(0, 1);
                post_states_valid = $urandom_range(0, 1);
                quit_at_end       = $urandom_range(0, 1);
            end
            reset = ($urandom_range(0, 299) != 0);
            step();
        end
        reset = 1;
        pre_states_valid = 1; post_states_valid = 1; quit_at_end = 1;
        idle_inputs();
        do_reset();

        // finish mid-loop freezes everything
        cur_state = S_PRE; step();
        cur_state = S_PP0; step();
        iter_start_enable = 1; run(3);
        finish = 1; step();
        chk("dump_pulse", 32'(dump_valid), 32'd1);
        step();
        chk("dump_single", 32'(dump_valid), 32'd0);
        finish = 0; ap_start = 1; run(4);
        chk("frozen_starts", 32'(iter_start_cnt), 32'd3);
        chk("frozen_busy", 32'(mod_busy), 32'd0);

        // asynchronous reset while busy and in loop
        ap_start = 0; iter_start_enable = 0; cur_state = '0;
        do_reset();
        ap_start = 1; step();
        ap_start = 0; cur_state = S_PRE; step();
        cur_state = S_PP0; step();
        iter_start_enable = 1; run(2);
        chk("pre_rst_busy", 32'(mod_busy), 32'd1);
        chk("pre_rst_loop", 32'(loop_active), 32'd1);
        #2;
        reset = 0;
        model_reset();
        #1;
        chk("async_busy", 32'(mod_busy), 32'd0);
        chk("async_loop", 32'(loop_active), 32'd0);
        chk("async_starts", 32'(iter_start_cnt), 32'd0);
        chk("async_entry", 32'(loop_entry_cnt), 32'd0);
        check_all();
        step();
        reset = 1;
        idle_inputs();
        run(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
